// File: rtl/result_display_pkg.sv
// result_display_pkg
//   Shared constants for the result display block:
//   - DEPTH_DEFAULT  : default number of history entries
//   - SEG_DASH       : segment pattern for "-"     ({g,f,e,d,c,b,a}, active-low)
//   - SEG_BLANK      : segment pattern with all segments off
//   - HEX_SEG_TABLE  : hex digit 0..F to active-low 7-segment code
package result_display_pkg;

  localparam int DEPTH_DEFAULT = 8;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Element [n] is the code for hex digit n (element 0 is the rightmost).
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/result_display_hex_to_seg7.sv
// hex_to_seg7
//   Purely combinational hex digit to 7-segment decoder.
//   Ports:
//     i_hex : 4-bit hex digit
//     o_seg : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
  import result_display_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG_TABLE[i_hex];

endmodule

// File: rtl/result_display.sv
// result_display
//   Keeps a circular history of processor results and shows one entry on a
//   4-digit multiplexed 7-segment display. The user can browse back through
//   older entries; the decimal point of digit 0 lights while browsing.
//   Ports:
//     clk_in      : system clock, rising edge
//     reset       : synchronous, active-high
//     result_in   : 16-bit result value
//     capture     : strobe, store result_in into history
//     browse_prev : strobe, step to the older entry
//     browse_next : strobe, step to the newer entry
//     anode       : digit enables, active-low, one-hot-low
//     seg         : segments {g,f,e,d,c,b,a}, active-low
//     dp          : decimal point, active-low
//     entry_idx   : current browse offset (0 = newest)
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,       // clk_in cycles per digit slot, >= 2
  parameter int DEPTH       = DEPTH_DEFAULT // history entries, power of two, >= 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] result_in,
  input  logic        capture,
  input  logic        browse_prev,
  input  logic        browse_next,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  entry_idx
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REF_W = $clog2(REFRESH_DIV);

  // History and browse state
  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_offset;

  logic [CNT_W-1:0] w_count_cap;
  logic [PTR_W-1:0] w_offset_cap;
  logic [PTR_W-1:0] w_offset_next;
  logic [PTR_W-1:0] w_rd_addr;

  // Display value pipeline
  logic [15:0] r_value;
  logic        r_empty;

  // Scan state
  logic [REF_W-1:0] r_refresh;
  logic [1:0]       r_digit_sel;
  logic             r_rst_d;
  logic [3:0]       r_anode;
  logic [6:0]       r_seg;
  logic             r_dp;

  logic [3:0] w_nibble;
  logic [6:0] w_seg_code;

  // Capture is applied first, then at most one browse step on the result.
  always_comb begin
    w_count_cap  = r_count;
    w_offset_cap = r_offset;
    if (capture) begin
      if (r_count != CNT_W'(DEPTH)) begin
        w_count_cap = r_count + CNT_W'(1);
      end
      // Track the same entry while browsing: it moved one step further back.
      if (r_offset != '0 && ({1'b0, r_offset} + CNT_W'(1)) < w_count_cap) begin
        w_offset_cap = r_offset + PTR_W'(1);
      end
    end

    w_offset_next = w_offset_cap;
    if (browse_prev && !browse_next) begin
      if (w_count_cap != '0 && ({1'b0, w_offset_cap} + CNT_W'(1)) < w_count_cap) begin
        w_offset_next = w_offset_cap + PTR_W'(1);
      end
    end else if (browse_next && !browse_prev) begin
      if (w_offset_cap != '0) begin
        w_offset_next = w_offset_cap - PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_offset <= '0;
    end else begin
      if (capture) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_count  <= w_count_cap;
      r_offset <= w_offset_next;
    end
  end

  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign w_rd_addr = r_wr_ptr - PTR_W'(1) - r_offset;

  // Block RAM with registered read. Reading from the current pointer/offset
  // makes the shown value follow any event one cycle later.
  always_ff @(posedge clk_in) begin
    if (capture && !reset) begin
      r_mem[r_wr_ptr] <= result_in;
    end
    r_value <= r_mem[w_rd_addr];
  end

  // Empty flag is delayed alongside r_value so the two stay aligned.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_empty <= 1'b1;
    end else begin
      r_empty <= (r_count == '0);
    end
  end

  // Refresh divider and digit select
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_refresh   <= '0;
      r_digit_sel <= '0;
    end else if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
      r_refresh   <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;
    end else begin
      r_refresh   <= r_refresh + REF_W'(1);
    end
  end

  assign w_nibble = r_value[{r_digit_sel, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nibble),
    .o_seg (w_seg_code)
  );

  // Outputs stay blank while reset is held and for one cycle afterwards.
  always_ff @(posedge clk_in) begin
    r_rst_d <= reset;
    if (reset || r_rst_d) begin
      r_anode <= 4'b1111;
      r_seg   <= SEG_BLANK;
      r_dp    <= 1'b1;
    end else begin
      r_anode <= ~(4'b0001 << r_digit_sel);
      r_seg   <= r_empty ? SEG_DASH : w_seg_code;
      r_dp    <= !(r_digit_sel == 2'd0 && r_offset != '0);
    end
  end

  assign anode     = r_anode;
  assign seg       = r_seg;
  assign dp        = r_dp;
  assign entry_idx = 3'(r_offset);

endmodule

// File: tb/tb_result_display.sv
// tb_result_display
//   Directed bench for result_display with a small reference model of the
//   history/browse behaviour. Expected digits are queued when stimulus is
//   applied and compared as the display scans them.
module tb_result_display;

  localparam int RD = 4;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [15:0] result_in;
  logic        capture;
  logic        browse_prev;
  logic        browse_next;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  entry_idx;

  result_display #(.REFRESH_DIV(RD), .DEPTH(8)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .result_in   (result_in),
    .capture     (capture),
    .browse_prev (browse_prev),
    .browse_next (browse_next),
    .anode       (anode),
    .seg         (seg),
    .dp          (dp),
    .entry_idx   (entry_idx)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
  } exp_t;
  exp_t sb[$];

  // Reference model
  logic [15:0] m_hist [8];
  int m_wp  = 0;
  int m_cnt = 0;
  int m_off = 0;

  logic [6:0] seg_ref [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit cap, input bit prev, input bit nxt, input logic [15:0] v);
    if (cap) begin
      m_hist[m_wp] = v;
      m_wp = (m_wp + 1) % 8;
      if (m_cnt < 8) m_cnt++;
      if (m_off > 0) m_off = (m_off + 1 < m_cnt - 1) ? m_off + 1 : m_cnt - 1;
    end
    if (prev && !nxt) begin
      if (m_cnt > 0 && m_off < m_cnt - 1) m_off++;
    end else if (nxt && !prev) begin
      if (m_off > 0) m_off--;
    end
  endtask

  // Called at a negedge; inputs are sampled on the following posedge.
  task automatic drive(input bit cap, input bit prev, input bit nxt, input logic [15:0] v);
    capture = cap; browse_prev = prev; browse_next = nxt; result_in = v;
    model_step(cap, prev, nxt, v);
    @(negedge clk_in);
    capture = 1'b0; browse_prev = 1'b0; browse_next = 1'b0;
    $display("drive cap=%0b prev=%0b next=%0b val=%h -> model off=%0d cnt=%0d",
             cap, prev, nxt, v, m_off, m_cnt);
  endtask

  task automatic do_reset(input int n, input bit with_cap);
    reset = 1'b1; capture = with_cap; result_in = 16'hDEAD;
    @(negedge clk_in);
    chk("rst anode", 16'(anode), 16'hF);
    chk("rst seg", 16'(seg), 16'h7F);
    chk("rst dp", 16'(dp), 16'h1);
    chk("rst entry_idx", 16'(entry_idx), 16'h0);
    repeat (n - 1) @(negedge clk_in);
    reset = 1'b0; capture = 1'b0;
    m_wp = 0; m_cnt = 0; m_off = 0;
    @(negedge clk_in);
    chk("post-rst anode", 16'(anode), 16'hF);
    chk("post-rst seg", 16'(seg), 16'h7F);
    $display("reset released after %0d cycles (capture held=%0b)", n, with_cap);
  endtask

  task automatic check_display(input string tag);
    logic [15:0] val;
    exp_t e;
    bit found;
    val = m_hist[(m_wp - 1 - m_off + 16) % 8];
    for (int n = 0; n < 4; n++) begin
      e.tag   = $sformatf("%s d%0d", tag, n);
      e.anode = ~(4'b0001 << n);
      e.seg   = (m_cnt == 0) ? 7'b0111111 : seg_ref[val[4*n +: 4]];
      e.dp    = (n == 0 && m_off > 0) ? 1'b0 : 1'b1;
      sb.push_back(e);
    end
    repeat (3) @(negedge clk_in);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      found = 1'b0;
      for (int i = 0; i < 8 * RD + 8 && !found; i++) begin
        if (anode === e.anode) found = 1'b1;
        else @(negedge clk_in);
      end
      chk({e.tag, " anode reached"}, 16'(found), 16'h1);
      chk({e.tag, " seg"}, 16'(seg), 16'(e.seg));
      chk({e.tag, " dp"}, 16'(dp), 16'(e.dp));
      $display("scan %s anode=%b seg=%b dp=%b", e.tag, anode, seg, dp);
    end
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0; browse_prev = 1'b0; browse_next = 1'b0;
    result_in = 16'h0;

    do_reset(3, 1'b0);
    check_display("empty");

    drive(0, 1, 0, 16'h0);
    chk("prev on empty", 16'(entry_idx), 16'(m_off));

    drive(1, 0, 0, 16'h1A2F);
    chk("1A2F entry_idx", 16'(entry_idx), 16'(m_off));
    check_display("1A2F");

    for (int v = 1; v <= 9; v++) drive(1, 0, 0, 16'(v));
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 0, 16'h0);
      chk($sformatf("prev%0d entry_idx", i), 16'(entry_idx), 16'(m_off));
    end
    chk("prev saturate", 16'(entry_idx), 16'd7);
    check_display("oldest");
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 16'h0);
      chk($sformatf("next%0d entry_idx", i), 16'(entry_idx), 16'(m_off));
    end
    check_display("live9");

    drive(0, 1, 0, 16'h0);
    drive(0, 1, 0, 16'h0);
    check_display("off2");
    drive(1, 0, 0, 16'h00AA);
    chk("cap in browse entry_idx", 16'(entry_idx), 16'd3);
    check_display("cap_in_browse");

    do_reset(2, 1'b0);
    drive(1, 0, 0, 16'h0011);
    drive(1, 0, 0, 16'h0022);
    drive(1, 0, 0, 16'h0033);
    drive(0, 1, 0, 16'h0);
    drive(0, 1, 1, 16'h0);
    chk("prev+next entry_idx", 16'(entry_idx), 16'd1);
    drive(1, 1, 0, 16'h0044);
    chk("cap+prev entry_idx", 16'(entry_idx), 16'(m_off));
    check_display("cap_prev");

    for (int v = 0; v < 5; v++) drive(1, 0, 0, 16'(16'h0100 + v));
    repeat (6) @(negedge clk_in);
    do_reset(2, 1'b1);
    check_display("after_reset");
    drive(1, 0, 0, 16'h1234);
    chk("1234 entry_idx", 16'(entry_idx), 16'h0);
    check_display("1234");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
